// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: drains one FRAME_LEN-word frame from the clock-crossing FIFO into a valid/ready stream
//   portb_clk/portb_rst  read-domain clock, asynchronous active-high reset
//   flush                synchronous abort: back to IDLE, buffered and in-flight words discarded
//   fifo_rd_en/_data     FIFO read port, data arrives RD_LATENCY cycles after the pop
//   fifo_empty/_full/_count  FIFO status in the read domain
//   out_valid/_ready/_data/_sof/_eof  output stream with frame markers
//   busy, frame_cnt, err_underrun     status
module fifo_frame_reader #(
  parameter int RAM_ADDR_WIDTH = 12,
  parameter int RAM_DATA_WIDTH = 32,
  parameter int FRAME_LEN      = 80,
  parameter int RD_LATENCY     = 0,
  parameter int FCNT_WIDTH     = 16
) (
  input  logic                      portb_clk,
  input  logic                      portb_rst,
  input  logic                      flush,
  output logic                      fifo_rd_en,
  input  logic [RAM_DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                      fifo_empty,
  input  logic                      fifo_full,
  input  logic [RAM_ADDR_WIDTH-1:0] fifo_count,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [RAM_DATA_WIDTH-1:0] out_data,
  output logic                      out_sof,
  output logic                      out_eof,
  output logic                      busy,
  output logic [FCNT_WIDTH-1:0]     frame_cnt,
  output logic                      err_underrun
);
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] FL = CW'(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] issued_q, issued_d, emitted_q, emitted_d;
  logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, pipe_q, pipe_d;
  logic [2:0] occ_q, occ_d, inflight;
  logic [FCNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic uf_q, uf_d, uf, push, pop, eof_hs;
  logic [RAM_DATA_WIDTH-1:0] mem_q [4];
  always_comb begin
    out_valid = occ_q != 3'd0;
    out_data = out_valid ? mem_q[rd_ptr_q] : '0;
    out_sof = out_valid && emitted_q == '0;
    out_eof = out_valid && emitted_q == LAST;
    busy = state_q != IDLE;
    frame_cnt = frame_cnt_q;
    inflight = '0;
    for (int i = 0; i < 2; i++)
      if (i < RD_LATENCY) inflight = inflight + 3'(pipe_q[i]);
    // popping stops once buffered plus in-flight words would exceed the 4-entry buffer
    fifo_rd_en = state_q == BURST && !fifo_empty && issued_q < FL && (4'(occ_q) + 4'(inflight)) < 4'd4 && !flush;
    push = fifo_rd_en;
    for (int i = 0; i < 2; i++)
      if (i == RD_LATENCY - 1) push = pipe_q[i];
    // err_underrun marks only the first cycle of each empty episode
    uf = state_q == BURST && fifo_empty && issued_q < FL;
    err_underrun = uf && !uf_q;
    pop = out_valid && out_ready;
    eof_hs = pop && emitted_q == LAST;
    pipe_d = flush ? 2'b00 : {pipe_q[0], fifo_rd_en};
    issued_d = (flush || eof_hs) ? '0 : issued_q + CW'(fifo_rd_en);
    emitted_d = (flush || eof_hs) ? '0 : emitted_q + CW'(pop);
    wr_ptr_d = flush ? 2'd0 : wr_ptr_q + 2'(push);
    rd_ptr_d = flush ? 2'd0 : rd_ptr_q + 2'(pop);
    occ_d = flush ? 3'd0 : occ_q + 3'(push) - 3'(pop);
    frame_cnt_d = frame_cnt_q + FCNT_WIDTH'(eof_hs && !flush);
    uf_d = uf && !flush;
    state_d = state_q;
    if (flush) state_d = IDLE;
    else if (state_q == IDLE && (fifo_count >= RAM_ADDR_WIDTH'(FRAME_LEN) || fifo_full)) state_d = BURST;
    else if (state_q != IDLE && eof_hs) state_d = IDLE;
    else if (state_q == BURST && issued_d == FL) state_d = DRAIN;
  end
  always_ff @(posedge portb_clk or posedge portb_rst) begin
    if (portb_rst) begin
      state_q <= IDLE;
      issued_q <= '0;
      emitted_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q <= '0;
      pipe_q <= '0;
      frame_cnt_q <= '0;
      uf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      issued_q <= issued_d;
      emitted_q <= emitted_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q <= occ_d;
      pipe_q <= pipe_d;
      frame_cnt_q <= frame_cnt_d;
      uf_q <= uf_d;
    end
  end
  always_ff @(posedge portb_clk)
    if (push) mem_q[wr_ptr_q] <= fifo_rd_data;
endmodule

// File: tb/tb_fifo_frame_reader.sv
// tb_fifo_frame_reader: directed and randomized frame transfers against a queue-based FIFO and stream model
module tb_fifo_frame_reader;
  localparam int AW = 12, DW = 32, FL = 80, RDL = 2, FW = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, flush, fifo_rd_en, fifo_empty, fifo_full, out_valid, out_ready;
  logic out_sof, out_eof, busy, err_underrun;
  logic [DW-1:0] fifo_rd_data, out_data;
  logic [AW-1:0] fifo_count;
  logic [FW-1:0] frame_cnt;
  fifo_frame_reader #(.RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW), .FRAME_LEN(FL), .RD_LATENCY(RDL), .FCNT_WIDTH(FW)) dut (
    .portb_clk(clk), .portb_rst(rst), .flush(flush), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof), .busy(busy),
    .frame_cnt(frame_cnt), .err_underrun(err_underrun)
  );
  logic [DW-1:0] fq[$], sent[$];
  logic [DW-1:0] d1, d2, st_data;
  logic [1:0] st_marks;
  bit force_empty, rand_ready, prev_cond, stall, done;
  int checks = 0, passes = 0, fails = 0, pops = 0, outst = 0, ecnt = 0, uf_pulses = 0, exp_fc = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive();
    fifo_count = AW'(fq.size());
    fifo_empty = fq.size() == 0 || force_empty;
    fifo_rd_data = RDL == 0 ? (fq.size() > 0 ? fq[0] : '0) : (RDL == 1 ? d1 : d2);
  endtask
  task automatic push_words(input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      fq.push_back(w);
      sent.push_back(w);
    end
    drive();
  endtask
  task automatic clear_model();
    fq.delete();
    sent.delete();
    d1 = '0;
    d2 = '0;
    pops = 0;
    outst = 0;
    ecnt = 0;
    prev_cond = 0;
    stall = 0;
    drive();
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk(tag, {26'd0, fifo_rd_en, out_valid, out_sof, out_eof, busy, err_underrun}, 32'd0);
    chk({tag, "_data"}, out_data, 32'd0);
    chk({tag, "_fcnt"}, 32'(frame_cnt), 32'd0);
  endtask
  // one clock: sample just before the edge, then advance the FIFO model after it
  task automatic tick();
    logic en, hs, cond;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    #4;
    en = fifo_rd_en;
    hs = out_valid && out_ready;
    cond = fifo_empty && busy && pops < FL;
    if (en) chk("pop_while_empty", 32'(fifo_empty), 32'd0);
    chk("underrun_pulse", 32'(err_underrun), 32'(cond && !prev_cond));
    if (err_underrun) uf_pulses++;
    prev_cond = cond;
    if (stall) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", out_data, st_data);
      chk("stall_marks", 32'({out_sof, out_eof}), 32'(st_marks));
    end
    stall = out_valid && !out_ready;
    st_data = out_data;
    st_marks = {out_sof, out_eof};
    if (en) begin
      pops++;
      outst++;
    end
    if (hs) begin
      chk("word_expected", 32'(sent.size() > 0), 32'd1);
      if (sent.size() > 0) chk("data", out_data, sent.pop_front());
      chk("sof", 32'(out_sof), 32'(ecnt == 0));
      chk("eof", 32'(out_eof), 32'(ecnt == FL - 1));
      ecnt++;
      outst--;
      if (ecnt == FL) begin
        chk("pops_per_frame", 32'(pops), 32'(FL));
        exp_fc = (exp_fc + 1) % (1 << FW);
        ecnt = 0;
        pops = 0;
        done = 1;
      end
    end
    chk("outstanding_le4", 32'(outst <= 4), 32'd1);
    @(posedge clk);
    @(negedge clk);
    d2 = d1;
    d1 = 32'hdead_beef;
    if (en && fq.size() > 0) d1 = fq.pop_front();
    drive();
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
    if (hs && ecnt == 0) chk("busy_after_eof", 32'(busy), 32'd0);
  endtask
  task automatic run_frame(input int limit);
    done = 0;
    for (int i = 0; i < limit && !done; i++) tick();
    chk("frame_completed", 32'(done), 32'd1);
  endtask
  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    fifo_full = 1'b0;
    force_empty = 0;
    rand_ready = 0;
    clear_model();
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    // below threshold nothing moves, the 80th word starts the burst
    push_words(FL - 1);
    repeat (10) tick();
    chk("no_pop_below_threshold", 32'(pops), 32'd0);
    chk("idle_below_threshold", 32'(busy), 32'd0);
    push_words(1);
    run_frame(400);
    // random backpressure
    rand_ready = 1;
    push_words(FL);
    run_frame(3000);
    rand_ready = 0;
    // underrun window at word 40
    push_words(FL);
    for (int i = 0; i < 300 && pops < 40; i++) tick();
    chk("reached_pop40", 32'(pops >= 40), 32'd1);
    force_empty = 1;
    drive();
    uf_pulses = 0;
    repeat (5) tick();
    chk("underrun_pulses", 32'(uf_pulses), 32'd1);
    force_empty = 0;
    drive();
    run_frame(400);
    // flush after 30 words
    push_words(FL);
    for (int i = 0; i < 300 && ecnt < 30; i++) tick();
    chk("reached_word30", 32'(ecnt >= 30), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    clear_model();
    push_words(FL);
    run_frame(400);
    // asynchronous reset between edges
    push_words(FL);
    for (int i = 0; i < 100 && pops < 10; i++) tick();
    #2 rst = 1'b1;
    #1 chk_reset_outputs("async_reset");
    exp_fc = 0;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    push_words(FL);
    run_frame(400);
    // fifo_full starts a short burst, then wrap through 15 -> 0 -> 1
    push_words(50);
    fifo_full = 1'b1;
    repeat (3) tick();
    chk("full_starts_burst", 32'(busy), 32'd1);
    fifo_full = 1'b0;
    repeat (60) tick();
    push_words(FL - 50);
    run_frame(400);
    for (int f = 0; f < 15; f++) begin
      push_words(FL);
      run_frame(400);
    end
    chk("wrap_final", 32'(frame_cnt), 32'd1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
